led_blink_sched: RTL and testbench
==================================

// Module: led_blink_sched
// PURPOSE
//  Shared-timebase LED pattern controller for the MiniBoard. A single prescaler
//  replaces per-LED divider counters. It produces a 1 ms tick, and that tick drives
//  all blink and water-light timing. A debounced push-button steps through four
//  display modes. Sits between the board clock/key pins and the LED pins.
// PARAMETERS
//  CLK_HZ       50_000_000  input clock frequency
//  TICK_HZ      1000        prescaler tick rate; DIV = CLK_HZ/TICK_HZ (integer, >=2)
//  DEBOUNCE_T   20          ticks key must be stable before accepted
//  HALF_SLOW_T  500         half-period of slow blink in ticks (1 Hz)
//  HALF_FAST_T  250         half-period of fast blink in ticks (2 Hz)
//  STEP_T       250         water-light step interval in ticks
// PORTS
//  clk_50M   in   1  system clock
//  rst       in   1  reset, asynchronous, active-high
//  key_n     in   1  raw push-button, active-low, asynchronous to clk_50M
//  led_out   out  4  LED drive, active-low (0 = lit)
//  mode_out  out  2  current mode, for status/debug
//  tick_out  out  1  one-cycle pulse per prescaler tick
// BEHAVIOUR
//  Reset (async, rst=1): prescaler=0, all phase counters=0, blink toggles=0,
//    water pointer=0, debounce stable=1, mode=0, led_out=4'hF, mode_out=0, tick_out=0.
//  Prescaler: counts 0..DIV-1 and wraps. Internal tick=1 exactly on the cycle when
//    count==DIV-1. The period is exactly DIV cycles, with no extra wrap cycle.
//    tick_out is tick registered, so it lags by 1 cycle.
//  Key path: 2-flop synchronizer on key_n. On each tick, if sync != stable,
//    deb_cnt++; otherwise deb_cnt=0. When deb_cnt reaches DEBOUNCE_T-1 while
//    sync != stable, stable<=sync and deb_cnt<=0.
//    press = 1-cycle pulse when stable goes 1->0. Release generates no event.
//  Mode FSM (2-bit, wraps): OFF(0) -> BLINK(1) -> WATER(2) -> ALL_ON(3) -> OFF.
//    Advances only on press.
//  On press: slow/fast phase counters, toggles and water pointer clear to 0 on the
//    same edge, so the new pattern starts at phase 0. The prescaler is not cleared.
//  Press and tick on the same cycle: the clear takes priority and that tick is not
//    counted by the phase counters.
//  Timers (tick-qualified):
//    slow_cnt 0..HALF_SLOW_T-1; at HALF_SLOW_T-1 with tick, slow_tgl flips and
//      slow_cnt wraps.
//    fast_cnt/fast_tgl behave identically with HALF_FAST_T.
//    step_cnt 0..STEP_T-1; at wrap, ptr<=ptr+1 mod 4.
//    All timers run in every mode; only the output mux depends on mode.
//  Output mux (led_out registered, 1-cycle latency after the state change):
//    OFF    : 4'hF
//    BLINK  : led_out = {~fast_tgl, fast_tgl, ~slow_tgl, slow_tgl}
//             (bit0 lit first half-period: bit0 = ~slow_tgl... drive value is
//             led_out[0]=slow_tgl so bit0 is lit while slow_tgl=0)
//    WATER  : led_out = ~(4'b0001 << ptr); exactly one LED lit
//    ALL_ON : 4'h0
//  mode_out = mode register, no extra latency.
//  Widths: every counter is sized by $clog2 of its limit and compared with
//    full-width constants. No truncation is allowed.
// TESTING (sim params: CLK_HZ=1000, TICK_HZ=100 -> DIV=10, DEBOUNCE_T=3,
//          HALF_SLOW_T=4, HALF_FAST_T=2, STEP_T=2)
//  1 Release rst, key_n=1 -> tick_out high 1 cycle every 10 clk; led_out=4'hF;
//    mode_out=0.
//  2 Hold key_n=0 for 5 ticks -> exactly one press; mode_out=1; led_out=4'b1010,
//    then bit0 toggles every 40 clk and bit2 every 20 clk.
//  3 Bounce key_n (0 for 2 ticks, then 1) -> no mode change; deb_cnt returns to 0.
//  4 Second press -> mode_out=2; led_out sequence 1110,1101,1011,0111,1110, one
//    step per 20 clk.
//  5 Two more presses -> mode 3 (led_out=0000), then mode 0 (led_out=1111); the
//    wrap 3->0 is checked.
//  6 Assert rst mid-WATER, asynchronously between clk edges -> led_out=4'hF and
//    mode_out=0 immediately, without waiting for clk; after release the prescaler
//    restarts from 0.

Source files
------------

// File: rtl/led_blink_sched.sv
// Shared-timebase LED pattern controller: one prescaler tick drives key debounce,
// blink and water-light timers; a debounced key press steps through four display modes.
module led_blink_sched #(
  parameter int CLK_HZ      = 50_000_000,
  parameter int TICK_HZ     = 1000,
  parameter int DEBOUNCE_T  = 20,
  parameter int HALF_SLOW_T = 500,
  parameter int HALF_FAST_T = 250,
  parameter int STEP_T      = 250
) (
  input  logic       clk_50M,
  input  logic       rst,
  input  logic       key_n,
  output logic [3:0] led_out,
  output logic [1:0] mode_out,
  output logic       tick_out
);

  localparam int DIV    = CLK_HZ / TICK_HZ;
  localparam int DIV_W  = (DIV > 1)         ? $clog2(DIV)         : 1;
  localparam int DEB_W  = (DEBOUNCE_T > 1)  ? $clog2(DEBOUNCE_T)  : 1;
  localparam int SLOW_W = (HALF_SLOW_T > 1) ? $clog2(HALF_SLOW_T) : 1;
  localparam int FAST_W = (HALF_FAST_T > 1) ? $clog2(HALF_FAST_T) : 1;
  localparam int STEP_W = (STEP_T > 1)      ? $clog2(STEP_T)      : 1;

  localparam logic [DIV_W-1:0]  DIV_MAX  = DIV_W'(DIV - 1);
  localparam logic [DEB_W-1:0]  DEB_MAX  = DEB_W'(DEBOUNCE_T - 1);
  localparam logic [SLOW_W-1:0] SLOW_MAX = SLOW_W'(HALF_SLOW_T - 1);
  localparam logic [FAST_W-1:0] FAST_MAX = FAST_W'(HALF_FAST_T - 1);
  localparam logic [STEP_W-1:0] STEP_MAX = STEP_W'(STEP_T - 1);

  typedef enum logic [1:0] {
    OFF    = 2'd0,
    BLINK  = 2'd1,
    WATER  = 2'd2,
    ALL_ON = 2'd3
  } mode_t;

  logic [DIV_W-1:0]  pre_cnt;
  logic              tick;
  logic              sync1, sync2;
  logic [DEB_W-1:0]  deb_cnt;
  logic              stable, stable_d;
  logic              press;
  mode_t             mode, mode_nxt;
  logic [SLOW_W-1:0] slow_cnt;
  logic [FAST_W-1:0] fast_cnt;
  logic [STEP_W-1:0] step_cnt;
  logic              slow_tgl, fast_tgl;
  logic [1:0]        ptr;

  function automatic logic [3:0] led_pattern(input mode_t m, input logic s_tgl,
                                             input logic f_tgl, input logic [1:0] p);
    case (m)
      BLINK:   led_pattern = {~f_tgl, f_tgl, ~s_tgl, s_tgl};
      WATER:   led_pattern = ~(4'b0001 << p);
      ALL_ON:  led_pattern = 4'h0;
      default: led_pattern = 4'hF;
    endcase
  endfunction

  // Prescaler: period of exactly DIV cycles, tick on the terminal count
  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      pre_cnt <= '0;
    end else if (pre_cnt == DIV_MAX) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + DIV_W'(1);
    end
  end

  assign tick = (pre_cnt == DIV_MAX);

  // Key path: synchronizer idles high so reset never looks like a press
  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      sync1    <= 1'b1;
      sync2    <= 1'b1;
      deb_cnt  <= '0;
      stable   <= 1'b1;
      stable_d <= 1'b1;
    end else begin
      sync1    <= key_n;
      sync2    <= sync1;
      stable_d <= stable;
      if (tick) begin
        if (sync2 != stable) begin
          if (deb_cnt == DEB_MAX) begin
            stable  <= sync2;
            deb_cnt <= '0;
          end else begin
            deb_cnt <= deb_cnt + DEB_W'(1);
          end
        end else begin
          deb_cnt <= '0;
        end
      end
    end
  end

  assign press = stable_d & ~stable;

  // Mode FSM
  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) mode <= OFF;
    else     mode <= mode_nxt;
  end

  always_comb begin
    mode_nxt = mode;
    if (press) begin
      case (mode)
        OFF:     mode_nxt = BLINK;
        BLINK:   mode_nxt = WATER;
        WATER:   mode_nxt = ALL_ON;
        default: mode_nxt = OFF;
      endcase
    end
  end

  // Pattern timers: a press restarts every pattern at phase 0 and swallows a coincident tick
  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      slow_cnt <= '0;
      fast_cnt <= '0;
      step_cnt <= '0;
      slow_tgl <= 1'b0;
      fast_tgl <= 1'b0;
      ptr      <= 2'd0;
    end else if (press) begin
      slow_cnt <= '0;
      fast_cnt <= '0;
      step_cnt <= '0;
      slow_tgl <= 1'b0;
      fast_tgl <= 1'b0;
      ptr      <= 2'd0;
    end else if (tick) begin
      if (slow_cnt == SLOW_MAX) begin
        slow_cnt <= '0;
        slow_tgl <= ~slow_tgl;
      end else begin
        slow_cnt <= slow_cnt + SLOW_W'(1);
      end
      if (fast_cnt == FAST_MAX) begin
        fast_cnt <= '0;
        fast_tgl <= ~fast_tgl;
      end else begin
        fast_cnt <= fast_cnt + FAST_W'(1);
      end
      if (step_cnt == STEP_MAX) begin
        step_cnt <= '0;
        ptr      <= ptr + 2'd1;
      end else begin
        step_cnt <= step_cnt + STEP_W'(1);
      end
    end
  end

  // Output register stage
  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      led_out  <= 4'hF;
      tick_out <= 1'b0;
    end else begin
      led_out  <= led_pattern(mode, slow_tgl, fast_tgl, ptr);
      tick_out <= tick;
    end
  end

  assign mode_out = mode;

endmodule

// File: tb/tb_led_blink_sched.sv
// Bench for led_blink_sched: tick-count reference model checked every cycle,
// plus directed key sequences with hand-computed LED expectations.
module tb_led_blink_sched;

  localparam int CLK_HZ = 1000;
  localparam int TICK_HZ = 100;
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int DEB = 3;
  localparam int HS = 4;
  localparam int HF = 2;
  localparam int ST = 2;

  logic       clk_50M = 1'b0;
  logic       rst;
  logic       key_n;
  logic [3:0] led_out;
  logic [1:0] mode_out;
  logic       tick_out;

  int checks = 0;
  int errors = 0;

  led_blink_sched #(
    .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .DEBOUNCE_T(DEB),
    .HALF_SLOW_T(HS), .HALF_FAST_T(HF), .STEP_T(ST)
  ) dut (
    .clk_50M (clk_50M),
    .rst     (rst),
    .key_n   (key_n),
    .led_out (led_out),
    .mode_out(mode_out),
    .tick_out(tick_out)
  );

  always #5 clk_50M = ~clk_50M;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the pattern is a pure function of mode and ticks since the last press
  int       m_cyc, m_T, m_run, m_mode;
  logic     m_stable, m_press, m_s1, m_s2, m_tick_out;
  logic [3:0] m_led;

  function automatic logic [3:0] led_for(input int mode, input int t);
    logic s, f;
    s = ((t / HS) % 2) == 1;
    f = ((t / HF) % 2) == 1;
    case (mode)
      1:       led_for = {~f, f, ~s, s};
      2:       led_for = ~(4'b0001 << ((t / ST) % 4));
      3:       led_for = 4'h0;
      default: led_for = 4'hF;
    endcase
  endfunction

  always @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      m_cyc <= 0; m_T <= 0; m_run <= 0; m_mode <= 0;
      m_stable <= 1'b1; m_press <= 1'b0; m_s1 <= 1'b1; m_s2 <= 1'b1;
      m_tick_out <= 1'b0; m_led <= 4'hF;
    end else begin
      automatic bit tk = ((m_cyc % DIV) == DIV - 1);
      m_cyc <= m_cyc + 1;
      m_tick_out <= tk;
      m_s1 <= key_n;
      m_s2 <= m_s1;
      m_press <= 1'b0;
      if (tk) begin
        if (m_s2 != m_stable) begin
          if (m_run + 1 == DEB) begin
            m_stable <= m_s2;
            m_run <= 0;
            m_press <= m_stable & ~m_s2;
          end else begin
            m_run <= m_run + 1;
          end
        end else begin
          m_run <= 0;
        end
      end
      if (m_press) begin
        m_mode <= (m_mode + 1) % 4;
        m_T <= 0;
      end else if (tk) begin
        m_T <= m_T + 1;
      end
      m_led <= led_for(m_mode, m_T);
    end
  end

  always @(negedge clk_50M) begin
    check("cyc_led_out", led_out, m_led);
    check("cyc_mode_out", mode_out, m_mode[1:0]);
    check("cyc_tick_out", tick_out, m_tick_out);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk_50M);
    #1;
  endtask

  task automatic press(input int hold);
    @(posedge clk_50M);
    #2;
    key_n = 1'b0;
    fork
      begin
        repeat (hold) @(posedge clk_50M);
        #2;
        key_n = 1'b1;
      end
    join_none
  endtask

  // Leaves time just after the edge on which mode_out changed
  task automatic wait_mode(input logic [1:0] from, input logic [1:0] to);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk_50M);
      #1;
      if (mode_out != from) begin
        seen = 1'b1;
        break;
      end
    end
    check("mode_change_seen", seen, 1);
    check("mode_after_press", mode_out, to);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    key_n = 1'b1;
    repeat (3) @(posedge clk_50M);
    #1;
    check("reset_led", led_out, 4'hF);
    check("reset_mode", mode_out, 2'd0);
    check("reset_tick", tick_out, 1'b0);
    #2;
    rst = 1'b0;

    // Idle: tick period and OFF pattern
    step(9);  check("tick_lo_9", tick_out, 1'b0);
    step(1);  check("tick_hi_10", tick_out, 1'b1);
    step(1);  check("tick_pulse_1cyc", tick_out, 1'b0);
    step(8);  check("tick_lo_19", tick_out, 1'b0);
    step(1);  check("tick_hi_20", tick_out, 1'b1);
    check("idle_led", led_out, 4'hF);
    check("idle_mode", mode_out, 2'd0);

    // First press -> BLINK
    press(5 * DIV);
    wait_mode(2'd0, 2'd1);
    step(1);  check("blink_e1", led_out, 4'b1010);
    step(18); check("blink_e19", led_out, 4'b1010);
    step(1);  check("blink_e20", led_out, 4'b0110);
    step(19); check("blink_e39", led_out, 4'b0110);
    step(1);  check("blink_e40", led_out, 4'b1001);
    step(80);
    check("single_press", mode_out, 2'd1);

    // Bounce shorter than the debounce window
    @(posedge clk_50M); #2; key_n = 1'b0;
    repeat (2 * DIV) @(posedge clk_50M);
    #2; key_n = 1'b1;
    step(80);
    check("bounce_no_change", mode_out, 2'd1);

    // Second press -> WATER
    press(5 * DIV);
    wait_mode(2'd1, 2'd2);
    step(1);  check("water_e1", led_out, 4'b1110);
    step(18); check("water_e19", led_out, 4'b1110);
    step(1);  check("water_e20", led_out, 4'b1101);
    step(20); check("water_e40", led_out, 4'b1011);
    step(20); check("water_e60", led_out, 4'b0111);
    step(20); check("water_e80", led_out, 4'b1110);
    step(60);

    // ALL_ON, then wrap back to OFF
    press(5 * DIV);
    wait_mode(2'd2, 2'd3);
    step(1);  check("all_on", led_out, 4'h0);
    step(120);
    press(5 * DIV);
    wait_mode(2'd3, 2'd0);
    step(1);  check("wrap_off", led_out, 4'hF);
    step(120);

    // Back to WATER, then async reset between edges
    press(5 * DIV);
    wait_mode(2'd0, 2'd1);
    step(120);
    press(5 * DIV);
    wait_mode(2'd1, 2'd2);
    step(120);
    @(posedge clk_50M);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_led", led_out, 4'hF);
    check("async_rst_mode", mode_out, 2'd0);
    check("async_rst_tick", tick_out, 1'b0);
    repeat (2) @(posedge clk_50M);
    #3;
    rst = 1'b0;
    step(9);  check("restart_tick_lo", tick_out, 1'b0);
    check("restart_led", led_out, 4'hF);
    step(1);  check("restart_tick_hi", tick_out, 1'b1);
    step(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
